// File: rtl/sba_pkg.sv
// Shared definitions for SBA bus infrastructure: bus widths, arbiter states
// and the read data returned when a transaction is terminated by the watchdog.
package sba_pkg;

    localparam int SBA_ADDR_W = 32;
    localparam int SBA_DATA_W = 32;
    localparam int SBA_WE_W   = 4;

    localparam logic [SBA_DATA_W-1:0] SBA_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } sba_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request found by
// scanning upward from (last + 1) mod N with wrap-around.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // The last slot visited is 'last' itself, so it only wins when it is
        // the sole requester.
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last) + i) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sba_arbiter.sv
// Round-robin arbiter sharing one SBA slave between NUM_MASTERS masters, with a
// mandatory release cycle after every transaction and an optional watchdog.
module sba_arbiter
    import sba_pkg::*;
#(
    parameter int                     NUM_MASTERS  = 2,
    parameter int                     TIMEOUT      = 255,
    parameter logic [SBA_DATA_W-1:0]  TIMEOUT_DATA = SBA_TIMEOUT_DATA
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [NUM_MASTERS-1:0]            i_m_stb,
    input  logic [SBA_ADDR_W*NUM_MASTERS-1:0] i_m_addr,
    input  logic [SBA_WE_W*NUM_MASTERS-1:0]   i_m_we,
    input  logic [SBA_DATA_W*NUM_MASTERS-1:0] i_m_dat_w,
    output logic [NUM_MASTERS-1:0]            o_m_ack,
    output logic [SBA_DATA_W-1:0]             o_m_dat_r,
    output logic                              o_s_stb,
    output logic [SBA_ADDR_W-1:0]             o_s_addr,
    output logic [SBA_WE_W-1:0]               o_s_we,
    output logic [SBA_DATA_W-1:0]             o_s_dat_w,
    input  logic                              i_s_ack,
    input  logic [SBA_DATA_W-1:0]             i_s_dat_r,
    output logic [NUM_MASTERS-1:0]            o_gnt,
    output logic                              o_timeout
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    sba_state_t    state;
    sba_state_t    state_next;
    logic [IW-1:0] grant;
    logic [IW-1:0] last;
    logic [CW-1:0] cnt;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          timeout_hit;

    logic [SBA_ADDR_W-1:0] m_addr_a  [NUM_MASTERS];
    logic [SBA_WE_W-1:0]   m_we_a    [NUM_MASTERS];
    logic [SBA_DATA_W-1:0] m_dat_w_a [NUM_MASTERS];

    always_comb begin
        for (int k = 0; k < NUM_MASTERS; k++) begin
            m_addr_a[k]  = i_m_addr[SBA_ADDR_W*k +: SBA_ADDR_W];
            m_we_a[k]    = i_m_we[SBA_WE_W*k +: SBA_WE_W];
            m_dat_w_a[k] = i_m_dat_w[SBA_DATA_W*k +: SBA_DATA_W];
        end
    end

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_pick (
        .req   (i_m_stb),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_VAL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(NUM_MASTERS - 1);
            cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_idx;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (state_next == GAP) begin
                        last <= grant;
                    end else if (cnt != TO_VAL) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Slave bus is only driven in BUSY; a real ack takes priority over abort
    // and over a watchdog expiry landing on the same cycle.
    always_comb begin
        state_next = state;
        o_gnt      = '0;
        o_m_ack    = '0;
        o_m_dat_r  = '0;
        o_s_stb    = 1'b0;
        o_s_addr   = '0;
        o_s_we     = '0;
        o_s_dat_w  = '0;
        o_timeout  = 1'b0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                o_gnt[grant] = 1'b1;
                o_s_stb      = i_m_stb[grant];
                o_s_addr     = m_addr_a[grant];
                o_s_we       = m_we_a[grant];
                o_s_dat_w    = m_dat_w_a[grant];
                if (i_m_stb[grant] && i_s_ack) begin
                    o_m_ack[grant] = 1'b1;
                    o_m_dat_r      = i_s_dat_r;
                    state_next     = GAP;
                end else if (!i_m_stb[grant]) begin
                    state_next = GAP;
                end else if (timeout_hit) begin
                    o_m_ack[grant] = 1'b1;
                    o_m_dat_r      = TIMEOUT_DATA;
                    o_timeout      = 1'b1;
                    o_s_stb        = 1'b0;
                    state_next     = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sba_arbiter.sv
// Self-checking bench for sba_arbiter with two masters, TIMEOUT = 8 and a
// one-cycle registered BRAM-style slave mapped at 0x1xxx_xxxx.
module tb_sba_arbiter;

    localparam int NM = 2;
    localparam int TO = 8;

    logic          i_clk;
    logic          i_rst_n;
    logic [NM-1:0] m_stb;
    logic [63:0]   m_addr;
    logic [7:0]    m_we;
    logic [63:0]   m_dat_w;
    logic [NM-1:0] m_ack;
    logic [31:0]   m_dat_r;
    logic          s_stb;
    logic [31:0]   s_addr;
    logic [3:0]    s_we;
    logic [31:0]   s_dat_w;
    logic          s_ack;
    logic [31:0]   s_dat_r;
    logic [NM-1:0] gnt;
    logic          timeout;

    int n_cmp = 0;
    int n_err = 0;

    sba_arbiter #(
        .NUM_MASTERS (NM),
        .TIMEOUT     (TO)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_m_stb   (m_stb),
        .i_m_addr  (m_addr),
        .i_m_we    (m_we),
        .i_m_dat_w (m_dat_w),
        .o_m_ack   (m_ack),
        .o_m_dat_r (m_dat_r),
        .o_s_stb   (s_stb),
        .o_s_addr  (s_addr),
        .o_s_we    (s_we),
        .o_s_dat_w (s_dat_w),
        .i_s_ack   (s_ack),
        .i_s_dat_r (s_dat_r),
        .o_gnt     (gnt),
        .o_timeout (timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Registered slave (ack <= stb): its ack stays high for one cycle after
    // completion, which lands in the arbiter's GAP cycle.
    logic [31:0] mem [16];
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s_ack   <= 1'b0;
            s_dat_r <= 32'h0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[1] <= 32'h1234_5678;
        end else begin
            s_ack   <= s_stb && (s_addr[31:28] == 4'h1);
            s_dat_r <= (s_we == 4'h0) ? mem[s_addr[5:2]] : 32'h0;
            if (s_stb && s_ack) begin
                for (int b = 0; b < 4; b++)
                    if (s_we[b]) mem[s_addr[5:2]][8*b +: 8] <= s_dat_w[8*b +: 8];
            end
        end
    end

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdat;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_to;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setMaster(input int m, input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdat);
        m_addr[32*m +: 32]  = addr;
        m_we[4*m +: 4]      = we;
        m_dat_w[32*m +: 32] = wdat;
    endtask

    // One isolated transaction: raise stb, wait for the ack, drop stb, and
    // check the release cycle that follows.
    task automatic applyStimulus(input vec_t v, input int n);
        int          cyc;
        bit          got;
        int          stb_lat;
        int          ack_lat;
        int          touts;
        logic [31:0] rd;
        logic [31:0] addr_seen;
        logic [NM-1:0] gnt_seen;
        string       tag;
        tag       = $sformatf("vec%0d", n);
        cyc       = 0;
        got       = 1'b0;
        stb_lat   = -1;
        ack_lat   = -1;
        touts     = 0;
        rd        = '0;
        addr_seen = '0;
        gnt_seen  = '0;
        @(posedge i_clk); #1;
        setMaster(v.m, v.addr, v.we, v.wdat);
        m_stb[v.m] = 1'b1;
        while (!got && cyc < 40) begin
            @(negedge i_clk);
            if (stb_lat < 0 && s_stb) begin
                stb_lat   = cyc;
                gnt_seen  = gnt;
                addr_seen = s_addr;
            end
            if (timeout) touts++;
            if (m_ack[v.m]) begin
                got     = 1'b1;
                ack_lat = cyc;
                rd      = m_dat_r;
            end
            if (!got) begin
                @(posedge i_clk); #1;
                cyc++;
            end
        end
        checkOutput({tag, "_ack_seen"}, 32'(got), 32'd1);
        checkOutput({tag, "_stb_lat"}, 32'(stb_lat), 32'd1);
        checkOutput({tag, "_gnt"}, 32'(gnt_seen), 32'(1 << v.m));
        checkOutput({tag, "_addr"}, addr_seen, v.addr);
        checkOutput({tag, "_ack_lat"}, 32'(ack_lat), 32'(v.exp_lat));
        checkOutput({tag, "_rdata"}, rd, v.exp_rd);
        checkOutput({tag, "_timeouts"}, 32'(touts), 32'(v.exp_to));
        @(posedge i_clk); #1;
        m_stb[v.m] = 1'b0;
        @(negedge i_clk);
        checkOutput({tag, "_gap_stb"}, 32'(s_stb), 32'd0);
        checkOutput({tag, "_gap_gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, "_gap_ack"}, 32'(m_ack), 32'd0);
        checkOutput({tag, "_gap_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_time_limit: simulation did not finish, expected $finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int a0, a1, g1, acks, last_c;
        logic [31:0] rd0;
        logic [NM-1:0] gap3, ack_or, gap_pend;
        bit found;

        vecs[0] = '{0, 32'h1000_0004, 4'h0, 32'h0,         32'h1234_AB78, 2, 0};
        vecs[1] = '{1, 32'h1000_0008, 4'hF, 32'h0102_0304, 32'h0,         2, 0};
        vecs[2] = '{1, 32'h1000_0008, 4'h0, 32'h0,         32'h0102_0304, 2, 0};
        vecs[3] = '{0, 32'h1000_0008, 4'h9, 32'hAA00_00BB, 32'h0,         2, 0};
        vecs[4] = '{0, 32'h1000_0008, 4'h0, 32'h0,         32'hAA02_03BB, 2, 0};
        vecs[5] = '{1, 32'h2000_0000, 4'h0, 32'h0,         32'hDEAD_BEEF, TO + 1, 1};
        vecs[6] = '{0, 32'h1000_0004, 4'h0, 32'h0,         32'h1234_AB78, 2, 0};
        vecs[7] = '{1, 32'h1000_000C, 4'h0, 32'h0,         32'h0,         2, 0};

        // Reset with non-zero master buses: nothing may reach the slave side.
        i_rst_n = 1'b0;
        m_stb   = '0;
        m_addr  = {32'h5555_5555, 32'hAAAA_AAAA};
        m_we    = 8'hFF;
        m_dat_w = {32'h1111_1111, 32'h2222_2222};
        repeat (3) @(negedge i_clk);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_s_stb", 32'(s_stb), 32'd0);
        checkOutput("rst_s_addr", s_addr, 32'd0);
        checkOutput("rst_s_we", 32'(s_we), 32'd0);
        checkOutput("rst_s_dat_w", s_dat_w, 32'd0);
        checkOutput("rst_m_ack", 32'(m_ack), 32'd0);
        checkOutput("rst_m_dat_r", m_dat_r, 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Simultaneous requests: m0 first; m1 (byte write) enters BUSY after
        // GAP and IDLE, i.e. three cycles after m0's ack.
        @(posedge i_clk); #1;
        setMaster(0, 32'h1000_0004, 4'h0, 32'h0);
        setMaster(1, 32'h1000_0004, 4'b0010, 32'h0000_AB00);
        m_stb = 2'b11;
        a0 = -1; a1 = -1; g1 = -1; rd0 = '0; gap3 = '1;
        for (int c = 0; c < 30 && a1 < 0; c++) begin
            @(negedge i_clk);
            if (gnt[1] && g1 < 0) g1 = c;
            if (m_ack[0] && a0 < 0) begin a0 = c; rd0 = m_dat_r; end
            if (m_ack[1] && a1 < 0) a1 = c;
            if (c == 3) gap3 = m_ack;
            @(posedge i_clk); #1;
            if (a0 >= 0) m_stb[0] = 1'b0;
            if (a1 >= 0) m_stb[1] = 1'b0;
        end
        checkOutput("sim_m0_ack_cycle", 32'(a0), 32'd2);
        checkOutput("sim_m0_rdata", rd0, 32'h1234_5678);
        checkOutput("sim_gap_ack", 32'(gap3), 32'd0);
        checkOutput("sim_m1_gnt_cycle", 32'(g1), 32'd5);
        checkOutput("sim_m1_ack_cycle", 32'(a1), 32'd6);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        // Continuous requests from both masters; last owner was m1 so m0 leads.
        @(posedge i_clk); #1;
        setMaster(0, 32'h1000_0004, 4'h0, 32'h0);
        setMaster(1, 32'h1000_0004, 4'h0, 32'h0);
        m_stb = 2'b11;
        acks = 0; last_c = 0; gap_pend = '0;
        for (int c = 0; c < 120 && acks < 10; c++) begin
            @(negedge i_clk);
            checkOutput("rr_gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (gap_pend != 0) checkOutput("rr_gap_ack", 32'(m_ack), 32'd0);
            gap_pend = '0;
            if (m_ack != 0) begin
                checkOutput("rr_order", 32'(m_ack), (acks % 2 == 0) ? 32'd1 : 32'd2);
                checkOutput("rr_rdata", m_dat_r, 32'h1234_AB78);
                if (acks > 0) checkOutput("rr_spacing", 32'(c - last_c), 32'd4);
                last_c   = c;
                acks++;
                gap_pend = '1;
            end
            @(posedge i_clk); #1;
        end
        m_stb = 2'b00;
        checkOutput("rr_ack_count", 32'(acks), 32'd10);
        @(negedge i_clk);
        checkOutput("rr_last_gap_ack", 32'(m_ack), 32'd0);
        @(negedge i_clk);

        // Abort: m0 drops stb in BUSY against a non-acking address.
        @(posedge i_clk); #1;
        setMaster(0, 32'h2000_0000, 4'h0, 32'h0);
        m_stb[0] = 1'b1;
        ack_or = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            ack_or = ack_or | m_ack;
            if (timeout) ack_or = ack_or | 2'b10;
            if (c == 4) begin
                checkOutput("abort_busy_stb", 32'(s_stb), 32'd0);
                checkOutput("abort_busy_gnt", 32'(gnt), 32'd1);
            end
            if (c == 5) checkOutput("abort_gap_gnt", 32'(gnt), 32'd0);
            if (c == 6) checkOutput("abort_idle_gnt", 32'(gnt), 32'd0);
            @(posedge i_clk); #1;
            if (c == 3) m_stb[0] = 1'b0;
        end
        checkOutput("abort_no_ack_or_timeout", 32'(ack_or), 32'd0);

        // Reset mid-BUSY of m1, then both request: m0 must win after release.
        setMaster(1, 32'h2000_0000, 4'h0, 32'h0);
        m_stb[1] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge i_clk);
            if (gnt[1]) found = 1'b1;
        end
        checkOutput("rst_mid_m1_granted", 32'(found), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_s_stb", 32'(s_stb), 32'd0);
        checkOutput("rst_mid_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_mid_ack", 32'(m_ack), 32'd0);
        setMaster(0, 32'h1000_0004, 4'h0, 32'h0);
        m_stb = 2'b11;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge i_clk);
            if (gnt != 0) begin
                found = 1'b1;
                checkOutput("post_rst_first_gnt", 32'(gnt), 32'd1);
            end
        end
        checkOutput("post_rst_grant_seen", 32'(found), 32'd1);
        @(posedge i_clk); #1;
        m_stb = 2'b00;
        repeat (4) @(negedge i_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
